// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP add/sub arbiter.
package fp_ctrl_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StClear
  } state_e;

  // Subtraction is an addition with B's sign bit flipped; NaN/Inf keep their class.
  function automatic logic [FP_W-1:0] negate_if(input logic [FP_W-1:0] x, input logic sub);
    return x ^ (FP_W'(sub) << SIGN_BIT);
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Requester and FP-unit signals of the shared add/sub controller.
interface fp_addsub_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import fp_ctrl_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_sub;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [FP_W-1:0]         rsp_data;
  logic                    rsp_timeout;
  logic [FP_W-1:0]         fu_a1;
  logic [FP_W-1:0]         fu_a2;
  logic                    fu_start;
  logic                    fu_reset;
  logic [FP_W-1:0]         fu_result;
  logic                    fu_done;

  // Environment side: requesters plus the FP unit.
  modport master (
    output req_valid, req_a, req_b, req_sub, fu_result, fu_done,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, fu_a1, fu_a2, fu_start, fu_reset
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_sub, fu_result, fu_done,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, fu_a1, fu_a2, fu_start, fu_reset
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW:0] NumReq = (IdxW+1)'(N);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IdxW+1)'(i);
      if (sum >= NumReq) begin
        sum = sum - NumReq;
      end
      j = sum[IdxW-1:0];
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one FP add/sub unit among NUM_REQ requesters with a done watchdog.
module fp_addsub_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset,
  fp_addsub_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     gidx_q;
  logic [CntW-1:0]     cnt_q;
  logic [FP_W-1:0]     a1_q, a2_q, rsp_data_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_tmo_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [IdxW-1:0]     gidx;
  logic                any;
  logic                accept, done_hit, tmo_hit;
  logic [FP_W-1:0]     a_arr [NUM_REQ];
  logic [FP_W-1:0]     b_arr [NUM_REQ];

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (gidx),
    .any   (any)
  );

  // Unpack the flat operand buses so the grant index can select a word.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = bus.req_a[i*FP_W +: FP_W];
      b_arr[i] = bus.req_b[i*FP_W +: FP_W];
    end
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, pointer advance and event strobes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    accept   = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          accept  = 1'b1;
          ptr_d   = (gidx == LastIdx) ? '0 : gidx + 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // done is only looked at here, so a stale level during ISSUE is ignored.
        if (bus.fu_done) begin
          done_hit = 1'b1;
          state_d  = StClear;
        end else if (cnt_q == CntMax) begin
          tmo_hit = 1'b1;
          state_d = StClear;
        end
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, watchdog count and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gidx_q      <= '0;
      cnt_q       <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        gidx_q <= gidx;
        a1_q   <= a_arr[gidx];
        a2_q   <= negate_if(b_arr[gidx], bus.req_sub[gidx]);
      end
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done_hit) begin
        rsp_data_q  <= bus.fu_result;
        rsp_tmo_q   <= 1'b0;
        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
      end else if (tmo_hit) begin
        rsp_data_q  <= QNAN;
        rsp_tmo_q   <= 1'b1;
        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
      end
    end
  end

  // Ready is masked in reset so a held request is not strobed before release.
  assign bus.req_ready   = (state_q == StIdle && reset) ? gnt : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_tmo_q;
  assign bus.fu_a1       = a1_q;
  assign bus.fu_a2       = a2_q;
  assign bus.fu_start    = (state_q == StIssue);
  // Hold the unit clear while the controller itself is in reset.
  assign bus.fu_reset    = ~reset | (state_q == StClear);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: table vectors plus scoreboarded hand sequences.
module tb_fp_addsub_arbiter;
  import fp_ctrl_pkg::*;

  localparam int NR  = 4;
  localparam int TMO = 8;

  typedef logic [1:0] rid_t;

  typedef struct {
    rid_t        idx;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] data;
    logic        tmo;
    logic        nan;
    int          cyc;
  } exp_t;

  typedef struct {
    rid_t        idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] a2;
    logic [31:0] data;
    logic        nan;
    int          lat;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_arbiter_if #(.NUM_REQ(NR)) bus ();

  fp_addsub_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb [$];
  rid_t        grants [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 2;
  bit          hang     = 1'b0;
  logic [31:0] cur_a    [NR];
  logic [31:0] cur_a2   [NR];
  logic [31:0] cur_data [NR];
  logic        cur_tmo  [NR];
  logic        cur_nan  [NR];
  vec_t        vecs     [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, want);
  endtask

  // Single-precision <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  // FP unit model: fixed latency after start, done held until fu_reset; hang never finishes.
  int fcnt = 0;
  always @(posedge clk) begin
    if (bus.fu_reset) begin
      bus.fu_done   <= 1'b0;
      bus.fu_result <= 32'd0;
      fcnt          <= 0;
    end else if (bus.fu_start) begin
      bus.fu_result <= fp_add(bus.fu_a1, bus.fu_a2);
      if (!hang) begin
        if (lat <= 1) bus.fu_done <= 1'b1;
        else fcnt <= lat - 1;
      end
    end else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) bus.fu_done <= 1'b1;
    end
  end

  // Monitor: push expectations on accept, check operands on start, pop on response.
  exp_t        mon_e;
  rid_t        mon_idx;
  logic [NR-1:0] mon_v;
  bit          mon_ok;
  always @(negedge clk) begin
    if (reset) begin
      if (|bus.req_ready) begin
        check($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0),
              "ready_onehot", 32'(bus.req_ready), 32'(bus.req_valid));
        check(bus.fu_reset == 1'b0, "fu_reset_idle", 32'(bus.fu_reset), 32'd0);
        mon_idx = '0;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) mon_idx = rid_t'(i);
        grants.push_back(mon_idx);
        mon_e.idx  = mon_idx;
        mon_e.a1   = cur_a[mon_idx];
        mon_e.a2   = cur_a2[mon_idx];
        mon_e.data = cur_data[mon_idx];
        mon_e.tmo  = cur_tmo[mon_idx];
        mon_e.nan  = cur_nan[mon_idx];
        mon_e.cyc  = cyc + 2 + (cur_tmo[mon_idx] ? TMO : lat);
        sb.push_back(mon_e);
      end
      if (bus.fu_start) begin
        if (sb.size() == 0) begin
          check(1'b0, "start_without_accept", 32'd1, 32'd0);
        end else begin
          check(bus.fu_a1 == sb[0].a1, "fu_a1", bus.fu_a1, sb[0].a1);
          check(bus.fu_a2 == sb[0].a2, "fu_a2", bus.fu_a2, sb[0].a2);
        end
      end
      if (|bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_v = NR'(1) << mon_e.idx;
          check(bus.rsp_valid == mon_v, "rsp_valid_owner", 32'(bus.rsp_valid), 32'(mon_v));
          if (mon_e.nan) begin
            mon_ok = (bus.rsp_data[30:23] == 8'hFF) && (bus.rsp_data[22:0] != 23'd0);
            check(mon_ok, "rsp_data_nan", bus.rsp_data, 32'h7FC0_0000);
          end else begin
            check(bus.rsp_data == mon_e.data, "rsp_data", bus.rsp_data, mon_e.data);
          end
          check(bus.rsp_timeout == mon_e.tmo, "rsp_timeout", 32'(bus.rsp_timeout),
                32'(mon_e.tmo));
          check(cyc == mon_e.cyc, "rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
          check(bus.fu_reset == 1'b1, "fu_reset_clear", 32'(bus.fu_reset), 32'd1);
        end
      end
    end
  end

  task automatic set_req(input rid_t idx, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] a2, input logic [31:0] data,
                         input logic tmo, input logic nan);
    logic [NR*32-1:0] mask;
    cur_a[idx]    = a;
    cur_a2[idx]   = a2;
    cur_data[idx] = data;
    cur_tmo[idx]  = tmo;
    cur_nan[idx]  = nan;
    mask = {{(NR*32-32){1'b0}}, 32'hFFFF_FFFF} << (32 * int'(idx));
    bus.req_a = (bus.req_a & ~mask) | ((NR*32)'(a) << (32 * int'(idx)));
    bus.req_b = (bus.req_b & ~mask) | ((NR*32)'(b) << (32 * int'(idx)));
    bus.req_sub[idx] = sub;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check(1'b0, {name, "_no_response"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #2;
    @(posedge clk); #2;
  endtask

  task automatic do_req(input rid_t idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] a2, input logic [31:0] data,
                        input logic tmo, input logic nan, input string name);
    bit got = 1'b0;
    set_req(idx, a, b, sub, a2, data, tmo, nan);
    bus.req_valid[idx] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) got = 1'b1;
    end
    if (!got) check(1'b0, {name, "_not_accepted"}, 32'd0, 32'd1);
    @(posedge clk); #2;
    bus.req_valid[idx] = 1'b0;
    wait_drain(name);
  endtask

  task automatic check_reset_vals(input string tag);
    check(bus.req_ready == '0, {tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check(bus.rsp_valid == '0, {tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check(bus.rsp_data == 32'd0, {tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check(bus.rsp_timeout == 1'b0, {tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check(bus.fu_a1 == 32'd0, {tag, "_fu_a1"}, bus.fu_a1, 32'd0);
    check(bus.fu_a2 == 32'd0, {tag, "_fu_a2"}, bus.fu_a2, 32'd0);
    check(bus.fu_start == 1'b0, {tag, "_fu_start"}, 32'(bus.fu_start), 32'd0);
    check(bus.fu_reset == 1'b1, {tag, "_fu_reset"}, 32'(bus.fu_reset), 32'd1);
  endtask

  initial begin
    rid_t want_order [5];
    bit   got;
    want_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    vecs[0] = '{idx: 2'd0, a: 32'h3FE0_0000, b: 32'h4050_0000, sub: 1'b0,
                a2: 32'h4050_0000, data: 32'h40A0_0000, nan: 1'b0, lat: 3};
    vecs[1] = '{idx: 2'd2, a: 32'h4050_0000, b: 32'h3FE0_0000, sub: 1'b1,
                a2: 32'hBFE0_0000, data: 32'h3FC0_0000, nan: 1'b0, lat: 1};
    vecs[2] = '{idx: 2'd1, a: 32'h7FC0_0000, b: 32'h3FE0_0000, sub: 1'b1,
                a2: 32'hBFE0_0000, data: 32'h7FC0_0000, nan: 1'b1, lat: 2};
    vecs[3] = '{idx: 2'd3, a: 32'h4000_0000, b: 32'h3F80_0000, sub: 1'b0,
                a2: 32'h3F80_0000, data: 32'h4040_0000, nan: 1'b0, lat: 5};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;

    // All four requesters valid from reset: 1.75+3.25, 2+1, 3.25-1.75, 2-1.
    lat = 1;
    set_req(2'd0, 32'h3FE0_0000, 32'h4050_0000, 1'b0, 32'h4050_0000, 32'h40A0_0000, 1'b0, 1'b0);
    set_req(2'd1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0);
    set_req(2'd2, 32'h4050_0000, 32'h3FE0_0000, 1'b1, 32'hBFE0_0000, 32'h3FC0_0000, 1'b0, 1'b0);
    set_req(2'd3, 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    bus.req_valid = '1;
    #1 reset = 1'b0;
    #11;
    check_reset_vals("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (grants.size() >= 5) got = 1'b1;
    end
    if (!got) check(1'b0, "rr_five_grants", 32'(grants.size()), 32'd5);
    @(posedge clk); #2;
    bus.req_valid = '0;
    wait_drain("rr");
    check(grants.size() == 5, "rr_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size())
        check(grants[i] == want_order[i], "rr_grant_order", 32'(grants[i]), 32'(want_order[i]));
    end

    // Table vectors, one request at a time.
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      do_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].a2, vecs[i].data,
             1'b0, vecs[i].nan, "vec");
    end

    // Unit never finishes: watchdog response, then a normal request is served.
    hang = 1'b1;
    do_req(2'd1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 32'h7FC0_0000,
           1'b1, 1'b0, "timeout");
    hang = 1'b0;
    lat  = 2;
    do_req(2'd2, 32'h3FE0_0000, 32'h4050_0000, 1'b0, 32'h4050_0000, 32'h40A0_0000,
           1'b0, 1'b0, "after_timeout");

    // Reset asserted while waiting on the unit: request is dropped.
    hang = 1'b1;
    set_req(2'd3, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b0);
    bus.req_valid[3] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[3]) got = 1'b1;
    end
    if (!got) check(1'b0, "midreset_not_accepted", 32'd0, 32'd1);
    @(posedge clk); #2;
    bus.req_valid[3] = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    bus.req_valid[2] = 1'b1;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    sb.delete();
    hang = 1'b0;
    @(posedge clk); #2;
    bus.req_valid = '0;
    @(posedge clk); #2;
    reset = 1'b1;
    lat = 3;
    do_req(2'd0, 32'h3FE0_0000, 32'h4050_0000, 1'b0, 32'h4050_0000, 32'h40A0_0000,
           1'b0, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Controller that shares one `fp_add_sub` unit among `NUM_REQ` requesters. It arbitrates round-robin and converts each granted request into the unit's start/done/reset sequence. It implements subtraction by flipping the sign of operand B and returns the result to the granted requester. A watchdog recovers from a unit that never asserts done. It sits between the requesting pipelines and the single shared FP adder.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `TIMEOUT`, 64: maximum WAIT cycles before abort (≥4).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept strobe; transfer when valid & ready.
- `req_a` in NUM_REQ*32: operand A, slice i for requester i.
- `req_b` in NUM_REQ*32: operand B.
- `req_sub` in NUM_REQ: 1 = A−B, 0 = A+B.
- `rsp_valid` out NUM_REQ: one-cycle response pulse to the owning requester.
- `rsp_data` out 32: result, held until the next response.
- `rsp_timeout` out 1: qualifies `rsp_valid`; 1 = aborted.
- `fu_a1`, `fu_a2` out 32 each: operands to the FP unit.
- `fu_start` out 1: start pulse.
- `fu_reset` out 1: active-high clear to the FP unit.
- `fu_result` in 32: FP unit result.
- `fu_done` in 1: FP unit done, level, cleared only by `fu_reset`.

## Operation
- States: IDLE, ISSUE, WAIT, CLEAR.
- **IDLE:**
  - Grant the first valid requester at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]` = 1 combinationally in that cycle.
  - Latch `g`, `fu_a1 <= req_a[g]`, and `fu_a2 <= req_b[g] ^ (req_sub[g] << 31)`.
  - Set `rr_ptr <= (g+1) mod NUM_REQ`, then go to ISSUE.
  - With no valid request, stay in IDLE; `rr_ptr` is unchanged.
- **ISSUE:** `fu_start` = 1 for exactly this cycle. Clear the timeout counter and go to WAIT.
- **WAIT:**
  - `fu_done` is sampled only in this state.
  - If `fu_done`: `rsp_data <= fu_result`, `rsp_timeout <= 0`, pulse `rsp_valid[g]`, go to CLEAR.
  - Else if count == TIMEOUT−1: `rsp_data <= 32'h7FC00000`, `rsp_timeout <= 1`, pulse `rsp_valid[g]`, go to CLEAR.
  - Else increment the count.
- **CLEAR:** `fu_reset` = 1 for one cycle, then go to IDLE.
- `fu_a1`/`fu_a2` hold stable from ISSUE through CLEAR.
- Responses have no backpressure; requesters must accept `rsp_valid` when it is presented.
- Subtraction flips only bit 31, so NaN and Inf operands propagate through the FP unit unchanged in class.
- A requester may keep `req_valid` high after acceptance; it is treated as a new request in the next IDLE, subject to rotation.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `req_ready` 0.
  - `rsp_valid` 0, `rsp_data` 0, `rsp_timeout` 0.
  - `fu_a1`/`fu_a2` 0, `fu_start` 0.
  - `fu_reset` 1: `fu_reset = ~reset | (state==CLEAR)`, so the unit is held clear during controller reset.
- Accept cycle T (IDLE). `fu_start` at T+1. WAIT from T+2.
- If `fu_done` is first seen at T+2+k, `rsp_valid` and `rsp_data` are valid at T+3+k, coincident with CLEAR. IDLE resumes at T+4+k.
- Minimum request-to-request spacing is 4 cycles plus FP latency.
- Timeout response arrives at T+3+TIMEOUT−1.
- Reset mid-operation: abandon immediately; no response is issued, and the request is lost.
- A `fu_done` already high in ISSUE is ignored; only WAIT samples it.

## Structure
- Package `fp_ctrl_pkg`: `FP_W`=32, `SIGN_BIT`=31, `QNAN`=32'h7FC00000, state enum.
- Sub-module `rr_arbiter`: combinational round-robin priority pick. Inputs: `req` vector, `ptr`. Outputs: one-hot grant, binary index, any-grant.
- Top level holds the FSM, operand/result registers, pointer and watchdog counter.

## Test plan
- Req0 A=0x3FE00000 (1.75), B=0x40500000 (3.25), sub=0 -> `rsp_valid[0]`, `rsp_data`=0x40A00000 (5.0), `rsp_timeout`=0.
- Req2 A=0x40500000, B=0x3FE00000, sub=1 -> `fu_a2`=0xBFE00000; `rsp_data`=0x3FC00000 (1.5) to requester 2 only.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0; each receives exactly its own result.
- FP-unit model never asserts done, TIMEOUT=8 -> response 10 cycles after accept with `rsp_timeout`=1, `rsp_data`=0x7FC00000, then `fu_reset` pulse and the next request served normally.
- Assert `reset`=0 during WAIT -> all outputs take reset values at once and `fu_reset`=1. After release, a new 1.75+3.25 request returns 0x40A00000.
- Req1 A=0x7FC00000 (NaN), B=0x3FE00000, sub=1 -> the result is NaN (exponent 0xFF, mantissa ≠0).
